// File: rtl/alu_wide_sequencer.sv
// Two-pass 16-bit ADD/AND/OR sequencer driving an external 8-bit ALU.
// Chains the low-byte carry internally and assembles the 16-bit result with C/Z/N flags.
module alu_wide_sequencer (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [15:0] opA,
    input  logic [15:0] opB,
    output logic        busy,
    output logic        done,
    output logic [15:0] result,
    output logic        carry,
    output logic        zero,
    output logic        negative,
    output logic        err,
    output logic [7:0]  alu_a,
    output logic [7:0]  alu_b,
    output logic        alu_cin,
    output logic [2:0]  alu_func,
    input  logic [7:0]  alu_result,
    input  logic        alu_cout
);

    typedef enum logic [1:0] {IDLE, LO, HI, DONE} stateT;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_AND = 2'b01;
    localparam logic [1:0] OP_OR  = 2'b10;
    localparam logic [1:0] OP_RSV = 2'b11;

    stateT       state;
    logic [15:0] aReg;
    logic [15:0] bReg;
    logic [1:0]  opReg;
    logic [7:0]  loByte;
    logic        cLo;

    logic [7:0]  hiByte;
    logic        hiCarry;
    logic [15:0] fullResult;
    logic        isAdd;

    function automatic logic [2:0] funcFor(input logic [1:0] o);
        case (o)
            OP_AND:  return 3'b001;
            OP_OR:   return 3'b010;
            default: return 3'b000;
        endcase
    endfunction

    // cLo is only ever set for ADD, so adding it is harmless for AND/OR.
    always_comb begin
        isAdd      = (opReg == OP_ADD);
        hiByte     = alu_result + {7'b0, cLo};
        hiCarry    = isAdd & (alu_cout | ((alu_result == 8'hFF) & cLo));
        fullResult = {hiByte, loByte};
    end

    // NOTE: all state and outputs use <= so every register samples pre-edge values together.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            aReg     <= '0;
            bReg     <= '0;
            opReg    <= '0;
            loByte   <= '0;
            cLo      <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            result   <= '0;
            carry    <= 1'b0;
            zero     <= 1'b0;
            negative <= 1'b0;
            err      <= 1'b0;
            alu_a    <= '0;
            alu_b    <= '0;
            alu_cin  <= 1'b0;
            alu_func <= '0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        aReg  <= opA;
                        bReg  <= opB;
                        opReg <= op;
                        busy  <= 1'b1;
                        if (op == OP_RSV) begin
                            state    <= DONE;
                            done     <= 1'b1;
                            err      <= 1'b1;
                            result   <= '0;
                            carry    <= 1'b0;
                            zero     <= 1'b1;
                            negative <= 1'b0;
                        end else begin
                            // ALU inputs are registered, so the low pass is set up from the ports now.
                            state    <= LO;
                            err      <= 1'b0;
                            alu_a    <= opA[7:0];
                            alu_b    <= opB[7:0];
                            alu_cin  <= 1'b0;
                            alu_func <= funcFor(op);
                        end
                    end
                end
                LO: begin
                    loByte  <= alu_result;
                    cLo     <= alu_cout & isAdd;
                    alu_a   <= aReg[15:8];
                    alu_b   <= bReg[15:8];
                    alu_cin <= alu_cout & isAdd;
                    state   <= HI;
                end
                HI: begin
                    result   <= fullResult;
                    carry    <= hiCarry;
                    zero     <= (fullResult == 16'h0000);
                    negative <= fullResult[15];
                    done     <= 1'b1;
                    alu_a    <= '0;
                    alu_b    <= '0;
                    alu_cin  <= 1'b0;
                    alu_func <= '0;
                    state    <= DONE;
                end
                DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_wide_sequencer.sv
// Directed bench for alu_wide_sequencer with a behavioural 8-bit ALU attached.
// Expected values are hand-computed 16-bit results and flags.
module tb_alu_wide_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [1:0]  op;
    logic [15:0] opA;
    logic [15:0] opB;
    logic        busy;
    logic        done;
    logic [15:0] result;
    logic        carry;
    logic        zero;
    logic        negative;
    logic        err;
    logic [7:0]  alu_a;
    logic [7:0]  alu_b;
    logic        alu_cin;
    logic [2:0]  alu_func;
    logic [7:0]  alu_result;
    logic        alu_cout;

    int assertCount = 0;
    int failCount   = 0;

    always #5 clk = ~clk;

    alu_wide_sequencer dut (
        .clk(clk), .rst(rst), .start(start), .op(op), .opA(opA), .opB(opB),
        .busy(busy), .done(done), .result(result), .carry(carry), .zero(zero),
        .negative(negative), .err(err), .alu_a(alu_a), .alu_b(alu_b),
        .alu_cin(alu_cin), .alu_func(alu_func), .alu_result(alu_result),
        .alu_cout(alu_cout)
    );

    // External 8-bit ALU; carry-in deliberately ignored.
    always_comb begin
        {alu_cout, alu_result} = 9'h000;
        case (alu_func)
            3'b000:  {alu_cout, alu_result} = {1'b0, alu_a} + {1'b0, alu_b};
            3'b001:  alu_result = alu_a & alu_b;
            3'b010:  alu_result = alu_a | alu_b;
            default: alu_result = 8'h00;
        endcase
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        assertCount++;
        assert (obs === exp) else begin
            failCount++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic runOp(input string name, input logic [1:0] o, input logic [15:0] a,
                         input logic [15:0] b, input logic expCin, input logic [15:0] expRes,
                         input logic expC, input logic expZ, input logic expN);
        start = 1'b1; op = o; opA = a; opB = b;
        tick();
        start = 1'b0;
        check({name, "_lo_busy"}, 16'(busy), 16'h1);
        check({name, "_lo_done"}, 16'(done), 16'h0);
        check({name, "_lo_alu_a"}, 16'(alu_a), 16'(a[7:0]));
        check({name, "_lo_alu_b"}, 16'(alu_b), 16'(b[7:0]));
        tick();
        check({name, "_hi_alu_a"}, 16'(alu_a), 16'(a[15:8]));
        check({name, "_hi_alu_b"}, 16'(alu_b), 16'(b[15:8]));
        check({name, "_hi_alu_cin"}, 16'(alu_cin), 16'(expCin));
        check({name, "_hi_done"}, 16'(done), 16'h0);
        tick();
        check({name, "_done"}, 16'(done), 16'h1);
        check({name, "_busy"}, 16'(busy), 16'h1);
        check({name, "_result"}, result, expRes);
        check({name, "_carry"}, 16'(carry), 16'(expC));
        check({name, "_zero"}, 16'(zero), 16'(expZ));
        check({name, "_neg"}, 16'(negative), 16'(expN));
        check({name, "_err"}, 16'(err), 16'h0);
        check({name, "_alu_a_idle"}, 16'(alu_a), 16'h0);
        tick();
        check({name, "_idle_done"}, 16'(done), 16'h0);
        check({name, "_idle_busy"}, 16'(busy), 16'h0);
        check({name, "_held"}, result, expRes);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; op = 2'b00; opA = 16'h0; opB = 16'h0;
        tick();
        tick();
        check("rst_busy", 16'(busy), 16'h0);
        check("rst_done", 16'(done), 16'h0);
        check("rst_result", result, 16'h0);
        check("rst_flags", {12'h0, carry, zero, negative, err}, 16'h0);
        check("rst_alu", {alu_a, alu_b}, 16'h0);
        check("rst_alu_ctl", {12'h0, alu_cin, alu_func}, 16'h0);
        rst = 1'b0;
        tick();
        check("idle_busy", 16'(busy), 16'h0);

        runOp("add_ff_01",   2'b00, 16'h00FF, 16'h0001, 1'b1, 16'h0100, 1'b0, 1'b0, 1'b0);
        runOp("add_ffff_01", 2'b00, 16'hFFFF, 16'h0001, 1'b1, 16'h0000, 1'b1, 1'b1, 1'b0);
        runOp("add_7fff_01", 2'b00, 16'h7FFF, 16'h0001, 1'b1, 16'h8000, 1'b0, 1'b0, 1'b1);
        runOp("and",         2'b01, 16'h8F0F, 16'hF0FF, 1'b0, 16'h800F, 1'b0, 1'b0, 1'b1);
        runOp("or",          2'b10, 16'h1234, 16'h4321, 1'b0, 16'h5335, 1'b0, 1'b0, 1'b0);

        // start pulsed during LO and HI with other operands must be ignored
        start = 1'b1; op = 2'b00; opA = 16'h0102; opB = 16'h0304;
        tick();
        check("ign_lo_busy", 16'(busy), 16'h1);
        opA = 16'hAAAA; opB = 16'h5555; op = 2'b10;
        tick();
        check("ign_hi_alu_a", 16'(alu_a), 16'h01);
        tick();
        start = 1'b0;
        check("ign_done", 16'(done), 16'h1);
        check("ign_result", result, 16'h0406);
        tick();
        check("ign_idle_done", 16'(done), 16'h0);
        check("ign_idle_busy", 16'(busy), 16'h0);
        tick();
        check("ign_no_second_done", 16'(done), 16'h0);
        check("ign_no_second_busy", 16'(busy), 16'h0);
        check("ign_result_held", result, 16'h0406);

        // reset asserted during HI aborts the operation
        start = 1'b1; op = 2'b00; opA = 16'h1111; opB = 16'h2222;
        tick();
        start = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("abort_busy", 16'(busy), 16'h0);
        check("abort_done", 16'(done), 16'h0);
        check("abort_result", result, 16'h0);
        check("abort_alu_a", 16'(alu_a), 16'h0);
        tick();
        check("abort_no_done", 16'(done), 16'h0);
        runOp("add_after_rst", 2'b00, 16'h0001, 16'h0001, 1'b0, 16'h0002, 1'b0, 1'b0, 1'b0);

        // reserved op completes in one cycle with err
        start = 1'b1; op = 2'b11; opA = 16'hDEAD; opB = 16'hBEEF;
        tick();
        start = 1'b0;
        check("rsv_done", 16'(done), 16'h1);
        check("rsv_busy", 16'(busy), 16'h1);
        check("rsv_err", 16'(err), 16'h1);
        check("rsv_result", result, 16'h0);
        check("rsv_flags", {13'h0, carry, zero, negative}, 16'h2);
        tick();
        check("rsv_done_clr", 16'(done), 16'h0);
        check("rsv_busy_clr", 16'(busy), 16'h0);
        check("rsv_err_held", 16'(err), 16'h1);
        start = 1'b1; op = 2'b00; opA = 16'h0003; opB = 16'h0004;
        tick();
        check("rsv_err_cleared", 16'(err), 16'h0);

        // start held high: next accept right after the DONE->IDLE cycle
        tick();
        tick();
        check("b2b_done1", 16'(done), 16'h1);
        check("b2b_res1", result, 16'h0007);
        opA = 16'h0010; opB = 16'h0020;
        tick();
        check("b2b_idle", 16'(busy), 16'h0);
        tick();
        check("b2b_accept2", 16'(busy), 16'h1);
        check("b2b_alu_a2", 16'(alu_a), 16'h10);
        start = 1'b0;
        tick();
        tick();
        check("b2b_done2", 16'(done), 16'h1);
        check("b2b_res2", result, 16'h0030);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
